// File: rtl/crater_carver_pkg.sv
// Shared types and constants for the terrain column store and the crater carver.
package crater_carver_pkg;
  localparam int COLS = 640;
  localparam int ROWS = 480;
  localparam int XW   = 10;
  localparam int SW   = 12;

  typedef logic [ROWS-1:0] col_t;
  typedef logic [XW-1:0]   coord_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_NEXT, ST_READ, ST_WAIT, ST_MODIFY, ST_WRITE, ST_DONE
  } carve_state_e;

  // floor(sqrt(r^2 - dx^2)); 0 once |dx| exceeds r
  function automatic int chord_len(input int r, input int dx);
    int rem;
    int h;
    rem = r * r - dx * dx;
    h   = 0;
    for (int i = 1; i < 64; i++)
      if (i * i <= rem) h = i;
    return h;
  endfunction
endpackage

// File: rtl/crater_carver_if.sv
// Impact request handshake plus terrain carve-read / write port bundle.
interface crater_carver_if;
  import crater_carver_pkg::*;
  logic   impact_valid, impact_ready;
  coord_t impact_x, impact_y;
  logic   wr_window;
  coord_t rd_addr;
  col_t   rd_data;
  logic   we;
  coord_t write_addr;
  col_t   write_data;
  logic   done;

  modport slave (
    input  impact_valid, impact_x, impact_y, wr_window, rd_data,
    output impact_ready, rd_addr, we, write_addr, write_data, done
  );
  modport master (
    output impact_valid, impact_x, impact_y, wr_window, rd_data,
    input  impact_ready, rd_addr, we, write_addr, write_data, done
  );
endinterface

// File: rtl/crater_carver_chord_lut.sv
// Half-chord ROM: |dx| -> floor(sqrt(R^2-dx^2)), built at elaboration.
module crater_carver_chord_lut
  import crater_carver_pkg::*;
#(
  parameter int RADIUS = 16
) (
  input  logic [5:0] adx_i,
  output logic [5:0] h_o
);
  logic [5:0] rom [0:63];

  // entries beyond RADIUS come out as 0 and are never addressed
  for (genvar g = 0; g < 64; g++) begin : g_rom
    assign rom[g] = 6'(chord_len(RADIUS, g));
  end

  assign h_o = rom[adx_i];
endmodule

// File: rtl/crater_carver.sv
// Carves a circular crater into the terrain column store by column read-modify-write.
module crater_carver
  import crater_carver_pkg::*;
#(
  parameter int RADIUS = 16
) (
  input logic             clk,
  input logic             reset,
  crater_carver_if.slave  bus
);
  carve_state_e         state_q;
  coord_t               cx_q, cy_q, rd_addr_q, write_addr_q;
  logic signed [SW-1:0] dx_q;
  col_t                 col_q;
  logic                 ready_q, done_q;

  logic signed [SW-1:0] x_d, lo_d, hi_d, lo_c, hi_c;
  logic [5:0]           adx_d, h_d;
  col_t                 mask_d;

  assign x_d   = $signed({2'b00, cx_q}) + dx_q;
  assign adx_d = dx_q[SW-1] ? 6'(-dx_q) : 6'(dx_q);

  crater_carver_chord_lut #(.RADIUS(RADIUS)) u_chord_lut (
    .adx_i (adx_d),
    .h_o   (h_d)
  );

  assign lo_d = $signed({2'b00, cy_q}) - $signed({6'b0, h_d});
  assign hi_d = $signed({2'b00, cy_q}) + $signed({6'b0, h_d});

  // range mask lo..hi clamped to the column; empty when the chord starts below the column
  always_comb begin
    lo_c   = lo_d[SW-1] ? '0 : lo_d;
    hi_c   = (hi_d > SW'(ROWS-1)) ? SW'(ROWS-1) : hi_d;
    mask_d = '0;
    for (int i = 0; i < ROWS; i++)
      mask_d[i] = (lo_d <= SW'(ROWS-1)) && (SW'(i) >= lo_c) && (SW'(i) <= hi_c);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cx_q         <= '0;
      cy_q         <= '0;
      dx_q         <= '0;
      rd_addr_q    <= '0;
      write_addr_q <= '0;
      col_q        <= '0;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: if (bus.impact_valid) begin
          cx_q    <= bus.impact_x;
          cy_q    <= bus.impact_y;
          dx_q    <= -SW'(RADIUS);
          ready_q <= 1'b0;
          state_q <= ST_NEXT;
        end
        // off-screen columns are skipped one per cycle without touching terrain
        ST_NEXT: begin
          if (dx_q > SW'(RADIUS)) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if (x_d[SW-1] || (x_d >= SW'(COLS))) begin
            dx_q <= dx_q + SW'(1);
          end else begin
            rd_addr_q <= x_d[XW-1:0];
            state_q   <= ST_READ;
          end
        end
        ST_READ: state_q <= ST_WAIT;
        ST_WAIT: begin
          col_q   <= bus.rd_data;
          state_q <= ST_MODIFY;
        end
        ST_MODIFY: begin
          col_q        <= col_q & ~mask_d;
          write_addr_q <= rd_addr_q;
          state_q      <= ST_WRITE;
        end
        ST_WRITE: if (bus.wr_window) begin
          dx_q    <= dx_q + SW'(1);
          state_q <= ST_NEXT;
        end
        ST_DONE: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // we must coincide with the window cycle itself, so it is gated combinationally
  assign bus.we           = (state_q == ST_WRITE) && bus.wr_window;
  assign bus.impact_ready = ready_q;
  assign bus.rd_addr      = rd_addr_q;
  assign bus.write_addr   = write_addr_q;
  assign bus.write_data   = col_q;
  assign bus.done         = done_q;
endmodule

// File: tb/tb_crater_carver.sv
// Directed bench: terrain RAM model, write monitor, and per-pixel circle reference.
module tb_crater_carver;
  import crater_carver_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  crater_carver_if bus();

  crater_carver #(.RADIUS(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  col_t ram [0:COLS-1];
  logic fill_req = 1'b0;
  logic win_mode = 1'b0;
  int   tick = 0;

  always @(posedge clk) begin
    if (fill_req) begin
      for (int c = 0; c < COLS; c++) ram[c] <= '1;
    end else if (bus.we) begin
      ram[bus.write_addr] <= bus.write_data;
    end
    bus.rd_data <= ram[bus.rd_addr];
  end

  always @(posedge clk) begin
    #1;
    tick++;
    bus.wr_window = win_mode ? ((tick % 8) == 0) : 1'b1;
  end

  int cyc = 0, we_cnt = 0, done_cnt = 0, bad_win = 0, order_err = 0;
  int first_a = 0, last_a = 0, done_cyc = 0, acc_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (bus.we) begin
        if (we_cnt == 0) first_a = int'(bus.write_addr);
        else if (int'(bus.write_addr) <= last_a) order_err++;
        last_a = int'(bus.write_addr);
        if (!bus.wr_window) bad_win++;
        we_cnt++;
      end
      if (bus.done) begin done_cnt++; done_cyc = cyc; end
      if (bus.impact_valid && bus.impact_ready) acc_cyc = cyc;
    end
  end

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit in_crater(int c, int y, int cx, int cy);
    return ((c - cx) * (c - cx) + (y - cy) * (y - cy)) <= 256;
  endfunction

  // columns whose RAM image differs from solid terrain minus the given craters
  function automatic int img_err(int ax, int ay, int bx, int by, int cmax);
    int   n;
    col_t e;
    n = 0;
    for (int c = 0; c < COLS; c++) begin
      e = '1;
      for (int y = 0; y < ROWS; y++)
        if (c <= cmax && (in_crater(c, y, ax, ay) || in_crater(c, y, bx, by))) e[y] = 1'b0;
      if (ram[c] !== e) n++;
    end
    return n;
  endfunction

  task automatic clr();
    we_cnt = 0; done_cnt = 0; bad_win = 0; order_err = 0; first_a = -1; last_a = -1;
  endtask

  task automatic fill();
    fill_req = 1'b1;
    @(posedge clk); #1;
    fill_req = 1'b0;
    clr();
  endtask

  task automatic start_impact(input int x, input int y, input string tag);
    int k;
    bus.impact_valid = 1'b1;
    bus.impact_x = 10'(x);
    bus.impact_y = 10'(y);
    k = 0;
    while (k < 400) begin
      @(negedge clk);
      if (bus.impact_ready) break;
      k++;
    end
    @(posedge clk); #1;
    bus.impact_valid = 1'b0;
    if (k >= 400) chk({tag, "_accept_timeout"}, 0, 1);
  endtask

  task automatic wait_done(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (done_cnt < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_done_seen"}, 64'(done_cnt >= n), 1);
  endtask

  initial begin
    bus.impact_valid = 1'b0;
    bus.impact_x = '0;
    bus.impact_y = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", bus.impact_ready, 1);
    chk("rst_we", bus.we, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_wr_addr", bus.write_addr, 0);
    chk("rst_wr_data_zero", 64'(bus.write_data == '0), 1);

    // 1: centred impact, window always open
    fill();
    start_impact(320, 240, "s1");
    wait_done(1, 1000, "s1");
    repeat (3) @(posedge clk); #1;
    chk("s1_we_cnt", we_cnt, 33);
    chk("s1_done_cnt", done_cnt, 1);
    chk("s1_first_col", first_a, 304);
    chk("s1_last_col", last_a, 336);
    chk("s1_order", order_err, 0);
    chk("s1_latency", done_cyc - acc_cyc, 167);
    chk("s1_c320_r223", ram[320][223], 1);
    chk("s1_c320_r224", ram[320][224], 0);
    chk("s1_c320_r256", ram[320][256], 0);
    chk("s1_c320_r257", ram[320][257], 1);
    chk("s1_c304_r240", ram[304][240], 0);
    chk("s1_c304_r239", ram[304][239], 1);
    chk("s1_c336_r241", ram[336][241], 1);
    chk("s1_image", img_err(320, 240, -1000, 0, 9999), 0);

    // 2: left edge clipping
    fill();
    start_impact(5, 100, "s2");
    wait_done(1, 1000, "s2");
    repeat (3) @(posedge clk); #1;
    chk("s2_we_cnt", we_cnt, 22);
    chk("s2_first_col", first_a, 0);
    chk("s2_last_col", last_a, 21);
    chk("s2_image", img_err(5, 100, -1000, 0, 9999), 0);

    // 3: bottom edge clipping
    fill();
    start_impact(320, 470, "s3");
    wait_done(1, 1000, "s3");
    repeat (3) @(posedge clk); #1;
    chk("s3_we_cnt", we_cnt, 33);
    chk("s3_c320_r453", ram[320][453], 1);
    chk("s3_c320_r454", ram[320][454], 0);
    chk("s3_c320_r479", ram[320][479], 0);
    chk("s3_image", img_err(320, 470, -1000, 0, 9999), 0);

    // 4: sparse write window
    fill();
    win_mode = 1'b1;
    start_impact(320, 240, "s4");
    wait_done(1, 3000, "s4");
    repeat (3) @(posedge clk); #1;
    win_mode = 1'b0;
    chk("s4_we_cnt", we_cnt, 33);
    chk("s4_we_outside_window", bad_win, 0);
    chk("s4_image", img_err(320, 240, -1000, 0, 9999), 0);

    // 5: reset right after the third column write
    fill();
    start_impact(320, 240, "s5");
    begin
      int k;
      k = 0;
      while (we_cnt < 3 && k < 200) begin
        @(negedge clk); #1;
        k++;
      end
      chk("s5_third_write_seen", we_cnt, 3);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("s5_we_in_reset", bus.we, 0);
    chk("s5_ready_in_reset", bus.impact_ready, 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (40) @(posedge clk); #1;
    chk("s5_no_done", done_cnt, 0);
    chk("s5_we_cnt", we_cnt, 3);
    chk("s5_image", img_err(320, 240, -1000, 0, 306), 0);

    // 6: impact presented while busy is held off until the first idle cycle
    fill();
    start_impact(320, 240, "s6a");
    repeat (10) @(posedge clk); #1;
    chk("s6_ready_busy", bus.impact_ready, 0);
    start_impact(100, 50, "s6b");
    chk("s6_done_before_accept", done_cnt, 1);
    chk("s6_accept_after_done", acc_cyc - done_cyc, 1);
    wait_done(2, 1000, "s6");
    repeat (3) @(posedge clk); #1;
    chk("s6_we_cnt", we_cnt, 66);
    chk("s6_image", img_err(320, 240, 100, 50, 9999), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
